line_deserializer: RTL and testbench

Fill-path stage that sits between the memory interface and the cache data array. It collects eight consecutive 32-bit memory words into one 256-bit cache line and presents the completed line to the cache with a single-cycle valid pulse. It is the counterpart of the write-back serializer: word 0 is received first and lands in bits [31:0], so one block's output can be fed straight into the other.

---
 rtl/cache_pkg.sv | 12 +
 rtl/line_deserializer.sv | 85 ++++++++
 tb/tb_line_deserializer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache fill/write-back definitions: word and line geometry used by
// the line deserializer and its write-back serializer counterpart.
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    typedef logic [WORD_W-1:0]                     word_t;
    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/line_deserializer.sv
// Collects WORDS consecutive memory words into one cache line and presents it
// with a single-cycle valid pulse; word 0 lands in the least significant slot.
module line_deserializer #(
    parameter int WORD_W = cache_pkg::WORD_W,
    parameter int WORDS  = cache_pkg::WORDS_PER_LINE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    word_valid,
    input  logic [WORD_W-1:0]       word_in,
    output logic                    word_ready,
    output logic                    busy,
    output logic                    line_valid,
    output logic [WORD_W*WORDS-1:0] line_out
);

    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [IDX_W-1:0]               idx;
    logic [WORDS-1:0][WORD_W-1:0]   staging;
    logic [WORDS-1:0][WORD_W-1:0]   line_next;
    logic                           accept;
    logic                           last;

    assign accept = word_valid && (state == COLLECT);
    // idx wrapping past WORDS-1 is the completion condition
    assign last   = accept && (idx == IDX_W'(WORDS - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The final word bypasses staging so the line is complete on the same edge.
    always_comb begin
        line_next            = staging;
        line_next[WORDS-1]   = word_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            staging  <= '0;
            line_out <= '0;
        end else begin
            if (state == IDLE && start) begin
                idx <= '0;
            end
            if (accept) begin
                staging[idx] <= word_in;
                idx          <= idx + 1'b1;
            end
            if (last) begin
                line_out <= line_next;
            end
        end
    end

    assign word_ready = (state == COLLECT);
    assign busy       = (state != IDLE);
    assign line_valid = (state == DONE);

endmodule

// File: tb/tb_line_deserializer.sv
// Directed bench for line_deserializer: basic, gapped, ignored-input,
// reset-mid-line, hold/back-to-back and serializer loopback scenarios.
module tb_line_deserializer;

    logic         clk;
    logic         rst;
    logic         start;
    logic         word_valid;
    logic [31:0]  word_in;
    logic         word_ready;
    logic         busy;
    logic         line_valid;
    logic [255:0] line_out;

    int checks;
    int failures;

    line_deserializer #(.WORD_W(32), .WORDS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_valid (word_valid),
        .word_in    (word_in),
        .word_ready (word_ready),
        .busy       (busy),
        .line_valid (line_valid),
        .line_out   (line_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one fill starting in IDLE; words are base + mult*k, optional 3-style
    // gaps before words 3 and 6, optional start pulse alongside word mid_start.
    task automatic do_fill(input string tag, input logic [31:0] base, input logic [31:0] mult,
                           input int gap_len, input int mid_start, input logic [255:0] prev,
                           output int latency, output logic [255:0] exp_line);
        int cyc;
        logic found;
        exp_line = '0;
        for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = base + mult * k;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        check({tag, "_ready"}, 256'(word_ready), 256'(1'b1));
        for (int k = 0; k < 8; k++) begin
            if (gap_len > 0 && (k == 3 || k == 6)) begin
                word_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    check({tag, "_gap_busy"}, 256'(busy), 256'(1'b1));
                    check({tag, "_gap_hold"}, line_out, prev);
                    step();
                    cyc++;
                end
            end
            word_valid = 1'b1;
            word_in    = base + mult * k;
            start      = (k == mid_start);
            check({tag, "_lv_early"}, 256'(line_valid), 256'(1'b0));
            check({tag, "_hold"}, line_out, prev);
            step();
            cyc++;
            start = 1'b0;
        end
        word_valid = 1'b0;
        word_in    = '0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (line_valid) found = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        check({tag, "_lv_seen"}, 256'(found), 256'(1'b1));
        latency = cyc;
        check({tag, "_line"}, line_out, exp_line);
        step();
        check({tag, "_lv_pulse"}, 256'(line_valid), 256'(1'b0));
        check({tag, "_idle"}, 256'(busy), 256'(1'b0));
    endtask

    initial begin
        int lat;
        int extra_lv;
        int extra_busy;
        logic [255:0] l1, l2, l3, l4, lc, la, lb, ll;
        logic [31:0]  w;

        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        word_valid = 1'b0;
        word_in    = '0;
        #1;
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_ready", 256'(word_ready), 256'(1'b0));
        check("rst_lv", 256'(line_valid), 256'(1'b0));
        check("rst_line", line_out, '0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic fill
        do_fill("basic", 32'h0, 32'h11111111, 0, -1, '0, lat, l1);
        check("basic_lat", 256'(lat), 256'(9));
        check("basic_w0", 256'(line_out[31:0]), 256'(32'h00000000));
        check("basic_w7", 256'(line_out[255:224]), 256'(32'h77777777));

        // Gapped fill: two 3-cycle gaps add 6 cycles
        do_fill("gap", 32'hA0, 32'h1, 3, -1, l1, lat, l2);
        check("gap_lat", 256'(lat), 256'(15));

        // word_valid while IDLE is ignored
        word_valid = 1'b1;
        word_in    = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            check("idle_ready", 256'(word_ready), 256'(1'b0));
            check("idle_busy", 256'(busy), 256'(1'b0));
            step();
            check("idle_hold", line_out, l2);
        end
        word_valid = 1'b0;
        word_in    = '0;
        do_fill("ign", 32'hB0, 32'h1, 0, -1, l2, lat, l3);
        check("ign_lat", 256'(lat), 256'(9));

        // start mid-COLLECT is not queued
        do_fill("midstart", 32'hB8, 32'h1, 0, 3, l3, lat, l4);
        extra_lv   = 0;
        extra_busy = 0;
        for (int i = 0; i < 12; i++) begin
            if (line_valid) extra_lv++;
            if (busy) extra_busy++;
            step();
        end
        check("midstart_extra_lv", 256'(extra_lv), 256'(0));
        check("midstart_extra_busy", 256'(extra_busy), 256'(0));

        // Reset after 4 words: outputs clear without a clock edge
        start = 1'b1;
        step();
        start = 1'b0;
        word_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            word_in = 32'hD0 + k;
            step();
        end
        word_valid = 1'b0;
        check("pre_rst_busy", 256'(busy), 256'(1'b1));
        #1 rst = 1'b1;
        #1;
        check("async_busy", 256'(busy), 256'(1'b0));
        check("async_line", line_out, '0);
        check("async_ready", 256'(word_ready), 256'(1'b0));
        check("async_lv", 256'(line_valid), 256'(1'b0));
        step();
        rst = 1'b0;
        step();
        do_fill("rstfill", 32'hC0, 32'h1, 0, -1, '0, lat, lc);
        check("rstfill_lat", 256'(lat), 256'(9));

        // Back-to-back fills, second starts immediately after the first pulse
        do_fill("b2b1", 32'h1, 32'h1, 0, -1, lc, lat, la);
        do_fill("b2b2", 32'h100, 32'h1, 0, -1, la, lat, lb);
        check("b2b2_lat", 256'(lat), 256'(9));

        // Loopback through a serializer reading word i from bits [i*32 +: 32]
        do_fill("loop", 32'hCAFE0000, 32'h1, 0, -1, lb, lat, ll);
        for (int i = 0; i < 8; i++) begin
            w = line_out[i*32 +: 32];
            check("loop_word", 256'(w), 256'(32'hCAFE0000 + i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
